veldt_mem_arbiter: RTL

Shares the Veldt core's single-port RAM between the instruction-fetch port and the load/store data port. Each requester uses a valid/ready request channel and a pulse response channel. Only one RAM transaction is outstanding at a time. Data wins fixed priority, with an anti-starvation override for fetch. Sits between the core pipeline and the RAM/memory interface (ram_* signals), and is formally checked in the same flow as the core.

---
 rtl/veldt_mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/veldt_mem_arbiter.sv
// Veldt memory arbiter: one single-port RAM shared by instruction fetch and load/store.
// One transaction in flight; data has fixed priority, fetch wins after STARVE_LIMIT denials.
module veldt_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_mask,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                ram_req_valid,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_mask,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int BUSY_W = $clog2(RAM_LATENCY + 1);
  localparam int STRV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BUSY_W-1:0] LAT_V   = BUSY_W'(RAM_LATENCY);
  localparam logic [BUSY_W-1:0] ONE_B   = BUSY_W'(1);
  localparam logic [BUSY_W-1:0] ZERO_B  = BUSY_W'(0);
  localparam logic [STRV_W-1:0] LIMIT_V = STRV_W'(STARVE_LIMIT);
  localparam logic [STRV_W-1:0] ONE_S   = STRV_W'(1);
  localparam logic [STRV_W-1:0] ZERO_S  = STRV_W'(0);

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  logic [BUSY_W-1:0] busy_q, busy_d;
  owner_e            owner_q, owner_d;
  logic              store_q, store_d;
  logic [STRV_W-1:0] starve_q, starve_d;
  logic              drop_q, drop_d;

  logic free, rsp_cycle, force_if, grant_d, grant_if, fetch_outstanding;

  // Grant, RAM request mux, response generation and next-state
  always_comb begin
    free              = (busy_q <= ONE_B);
    rsp_cycle         = reset && (busy_q == ONE_B);
    force_if          = if_req_valid && (starve_q == LIMIT_V);
    fetch_outstanding = (busy_q != ZERO_B) && (owner_q == OWN_IF);
    grant_d           = 1'b0;
    grant_if          = 1'b0;
    if (reset && free) begin
      grant_d  = d_req_valid && !force_if;
      grant_if = if_req_valid && !grant_d;
    end else begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
    end

    d_req_ready   = grant_d;
    if_req_ready  = grant_if;
    ram_req_valid = grant_d || grant_if;
    ram_we        = 1'b0;
    ram_mask      = {MASK_W{1'b0}};
    ram_addr      = {ADDR_W{1'b0}};
    ram_wdata     = {DATA_W{1'b0}};
    if (grant_d) begin
      ram_we    = d_req_we;
      ram_mask  = d_req_mask;
      ram_addr  = d_req_addr;
      ram_wdata = d_req_wdata;
    end else if (grant_if) begin
      ram_mask  = {MASK_W{1'b1}};
      ram_addr  = if_req_addr;
    end else begin
      ram_we    = 1'b0;
    end

    // A flush landing on the response cycle kills that response as well
    if_rsp_valid = rsp_cycle && (owner_q == OWN_IF) && !drop_q && !if_flush;
    d_rsp_valid  = rsp_cycle && (owner_q == OWN_D);
    if_rsp_data  = if_rsp_valid ? ram_rdata : {DATA_W{1'b0}};
    d_rsp_data   = (d_rsp_valid && !store_q) ? ram_rdata : {DATA_W{1'b0}};

    busy_d  = busy_q;
    owner_d = owner_q;
    store_d = store_q;
    if (grant_d || grant_if) begin
      busy_d  = LAT_V;
      owner_d = grant_d ? OWN_D : OWN_IF;
      store_d = grant_d && d_req_we;
    end else if (busy_q != ZERO_B) begin
      busy_d  = busy_q - ONE_B;
    end else begin
      busy_d  = ZERO_B;
    end

    if (if_req_valid && !grant_if) begin
      starve_d = (starve_q == LIMIT_V) ? starve_q : starve_q + ONE_S;
    end else begin
      starve_d = ZERO_S;
    end

    // Drop clears on the response cycle, so a fetch granted in that cycle is kept
    if (rsp_cycle) begin
      drop_d = 1'b0;
    end else if (fetch_outstanding && if_flush) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q   <= ZERO_B;
      owner_q  <= OWN_IF;
      store_q  <= 1'b0;
      starve_q <= ZERO_S;
      drop_q   <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      store_q  <= store_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
    end
  end

endmodule
